// File: rtl/msdf_mult_seq.sv
// -----------------------------------------------------------------------------
// msdf_mult_seq
// Sequencer for a radix-RADIX most-significant-digit-first online multiplier.
// Operand digit pairs (x_j, y_j) arrive MSD-first over a valid/ready handshake
// and are stored in the X/Y operand registers. Each iteration time-shares one
// partial-product generator between x_j*Y[j-1] (PP_X) and y_j*X[j] (PP_Y).
// Then it strobes the residual/selection datapath (SEL). From iteration DELTA
// onward, it buffers the selected digit onto a valid/ready result port (OUT).
// Iterations j >= N are tail iterations with zero operand digits.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start                begin an operation (sampled only in IDLE)
//   busy                 high in every state except IDLE
//   in_valid/in_ready    operand digit-pair handshake (in_ready only in ACCEPT)
//   x_digit, y_digit     signed D-bit operand digits
//   pp_a, pp_b           operand vector / multiplier digit for the PP generator
//   pp_en, pp_sel        PP strobe; pp_sel=0 x-product, 1 y-product
//   sel_en, sel_digit    selection strobe and selected digit from the datapath
//   out_valid/out_ready  result digit handshake, z_digit is the buffered digit
//   done                 one-cycle pulse at the end of an operation
// -----------------------------------------------------------------------------
module msdf_mult_seq #(
    parameter int RADIX = 4,
    parameter int N     = 8,
    parameter int DELTA = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           busy,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [$clog2(RADIX):0]         x_digit,
    input  logic [$clog2(RADIX):0]         y_digit,
    output logic [($clog2(RADIX)+1)*N-1:0] pp_a,
    output logic [$clog2(RADIX):0]         pp_b,
    output logic                           pp_en,
    output logic                           pp_sel,
    output logic                           sel_en,
    input  logic [$clog2(RADIX):0]         sel_digit,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(RADIX):0]         z_digit,
    output logic                           done
);

    localparam int D  = $clog2(RADIX) + 1;
    localparam int JW = $clog2(N + DELTA + 1);

    localparam logic [JW-1:0] J_N     = JW'(N);
    localparam logic [JW-1:0] J_END   = JW'(N + DELTA);
    localparam logic [JW-1:0] J_DELTA = JW'(DELTA);
    localparam logic [JW-1:0] J_LAST  = JW'(N - 1);
    localparam logic [JW-1:0] J_ONE   = JW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_PP_X   = 3'd2,
        ST_PP_Y   = 3'd3,
        ST_SEL    = 3'd4,
        ST_OUT    = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [D*N-1:0]    x_r;
    logic [D*N-1:0]    y_r;
    logic [D*N-1:0]    x_s;
    logic [D*N-1:0]    y_s;
    logic [JW-1:0]     j_r;
    logic [JW-1:0]     j_s;
    logic [D-1:0]      zreg_r;
    logic [D-1:0]      zreg_s;
    logic [JW-1:0]     slot_s;
    logic [JW-1:0]     j_inc_s;

    logic              busy_r;
    logic              in_ready_r;
    logic              pp_en_r;
    logic              pp_sel_r;
    logic              sel_en_r;
    logic              out_valid_r;
    logic              done_r;

    // Read digit 'slot' (0 = LSD) out of an N-digit vector.
    function automatic logic [D-1:0] get_digit(input logic [D*N-1:0] vec,
                                               input logic [JW-1:0]  slot);
        logic [D-1:0] d;
        d = {D{1'b0}};
        for (int k = 0; k < N; k++) begin
            if (JW'(k) == slot) begin
                d = vec[k*D +: D];
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

    // Return 'vec' with digit 'slot' replaced by 'val'.
    function automatic logic [D*N-1:0] put_digit(input logic [D*N-1:0] vec,
                                                 input logic [JW-1:0]  slot,
                                                 input logic [D-1:0]   val);
        logic [D*N-1:0] v;
        v = vec;
        for (int k = 0; k < N; k++) begin
            if (JW'(k) == slot) begin
                v[k*D +: D] = val;
            end else begin
                v[k*D +: D] = vec[k*D +: D];
            end
        end
        return v;
    endfunction

    // Operand digit j lives in slot N-1-j so that X/Y read as MSD-first prefixes.
    assign slot_s  = J_LAST - j_r;
    assign j_inc_s = j_r + J_ONE;

    // Next-state and register-update logic of the sequencer.
    always_comb begin
        state_s = state_r;
        x_s     = x_r;
        y_s     = y_r;
        j_s     = j_r;
        zreg_s  = zreg_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    x_s     = {(D*N){1'b0}};
                    y_s     = {(D*N){1'b0}};
                    j_s     = {JW{1'b0}};
                    state_s = ST_ACCEPT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCEPT: begin
                if (in_valid) begin
                    x_s     = put_digit(x_r, slot_s, x_digit);
                    y_s     = put_digit(y_r, slot_s, y_digit);
                    state_s = ST_PP_X;
                end else begin
                    state_s = ST_ACCEPT;
                end
            end
            ST_PP_X: begin
                state_s = ST_PP_Y;
            end
            ST_PP_Y: begin
                state_s = ST_SEL;
            end
            ST_SEL: begin
                if (j_r >= J_DELTA) begin
                    zreg_s  = sel_digit;
                    state_s = ST_OUT;
                end else begin
                    // Warm-up iteration: no result digit is produced yet.
                    j_s = j_inc_s;
                    if (j_inc_s < J_N) begin
                        state_s = ST_ACCEPT;
                    end else begin
                        state_s = ST_PP_X;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    j_s = j_inc_s;
                    if (j_inc_s == J_END) begin
                        state_s = ST_DONE;
                    end else if (j_inc_s < J_N) begin
                        state_s = ST_ACCEPT;
                    end else begin
                        state_s = ST_PP_X;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, operand/result registers and registered state-decoded outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            x_r         <= {(D*N){1'b0}};
            y_r         <= {(D*N){1'b0}};
            j_r         <= {JW{1'b0}};
            zreg_r      <= {D{1'b0}};
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            pp_en_r     <= 1'b0;
            pp_sel_r    <= 1'b0;
            sel_en_r    <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            x_r         <= x_s;
            y_r         <= y_s;
            j_r         <= j_s;
            zreg_r      <= zreg_s;
            busy_r      <= (state_s != ST_IDLE);
            in_ready_r  <= (state_s == ST_ACCEPT);
            pp_en_r     <= (state_s == ST_PP_X) || (state_s == ST_PP_Y);
            pp_sel_r    <= (state_s == ST_PP_Y);
            sel_en_r    <= (state_s == ST_SEL);
            out_valid_r <= (state_s == ST_OUT);
            done_r      <= (state_s == ST_DONE);
        end
    end

    // Partial-product operand mux; zero whenever the generator is not strobed.
    // PP_X uses Y[j-1]: the freshly written y_j slot is masked out.
    always_comb begin
        pp_a = {(D*N){1'b0}};
        pp_b = {D{1'b0}};
        if (pp_en_r && !pp_sel_r) begin
            if (j_r < J_N) begin
                pp_a = put_digit(y_r, slot_s, {D{1'b0}});
                pp_b = get_digit(x_r, slot_s);
            end else begin
                pp_a = y_r;
                pp_b = {D{1'b0}};
            end
        end else if (pp_en_r && pp_sel_r) begin
            pp_a = x_r;
            if (j_r < J_N) begin
                pp_b = get_digit(y_r, slot_s);
            end else begin
                pp_b = {D{1'b0}};
            end
        end else begin
            pp_a = {(D*N){1'b0}};
            pp_b = {D{1'b0}};
        end
    end

    assign busy      = busy_r;
    assign in_ready  = in_ready_r;
    assign pp_en     = pp_en_r;
    assign pp_sel    = pp_sel_r;
    assign sel_en    = sel_en_r;
    assign out_valid = out_valid_r;
    assign done      = done_r;
    assign z_digit   = zreg_r;

endmodule

// File: tb/tb_msdf_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_msdf_mult_seq
// Self-checking bench for msdf_mult_seq (RADIX=4, N=8, DELTA=3). A table of
// directed operations and a set of randomized operations run through one
// driver/monitor task. The reference model works at the algorithm level.
// The expected partial-product operands are the prefix values Y[j-1] and X[j],
// built from the operand digit lists. The expected result stream is the
// selection digits offered in iterations j >= DELTA.
// -----------------------------------------------------------------------------
module tb_msdf_mult_seq;

    localparam int RADIX = 4;
    localparam int N     = 8;
    localparam int DELTA = 3;
    localparam int D     = 3;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           start     = 1'b0;
    logic           in_valid  = 1'b0;
    logic           out_ready = 1'b0;
    logic [D-1:0]   x_digit   = 3'd0;
    logic [D-1:0]   y_digit   = 3'd0;
    logic [D-1:0]   sel_digit = 3'd0;
    logic           busy, in_ready, pp_en, pp_sel, sel_en, out_valid, done;
    logic [D*N-1:0] pp_a;
    logic [D-1:0]   pp_b, z_digit;

    int total = 0;
    int bad   = 0;

    msdf_mult_seq #(.RADIX(RADIX), .N(N), .DELTA(DELTA)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_digit(x_digit), .y_digit(y_digit),
        .pp_a(pp_a), .pp_b(pp_b), .pp_en(pp_en), .pp_sel(pp_sel),
        .sel_en(sel_en), .sel_digit(sel_digit),
        .out_valid(out_valid), .out_ready(out_ready),
        .z_digit(z_digit), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [D*N-1:0] xv;          // operand digit j at [j*D +: D]
        logic [D*N-1:0] yv;
        int             in_stall_j;  // hold in_valid low in ACCEPT of this j
        int             in_stall_len;
        int             out_stall_k; // hold out_ready low on this result
        int             out_stall_len;
        bit             sel_fix_en;
        logic [D-1:0]   sel_fix;
        int             busy_start_j; // pulse start once acc reaches this j
        int             reset_y;      // assert reset in PP_Y of this j
        int             exp_cycles;   // start cycle to done cycle, -1 = skip
        bit             rnd;          // random valid/ready
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [D-1:0] dig(input logic [D*N-1:0] v, input int i);
        return v[i*D +: D];
    endfunction

    // Y[j-1]: digits y_0..y_{j-1} placed MSD-first (y_i in slot N-1-i).
    function automatic logic [D*N-1:0] prefix(input logic [D*N-1:0] v, input int cnt);
        logic [D*N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (i < cnt) r[(N-1-i)*D +: D] = v[i*D +: D];
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [D*N-1:0] xv, input logic [D*N-1:0] yv,
                                input int isj, input int isl, input int osk, input int osl,
                                input bit sfe, input logic [D-1:0] sf, input int bsj,
                                input int ry, input int ec, input bit rnd);
        vec_t v;
        v.xv = xv; v.yv = yv; v.in_stall_j = isj; v.in_stall_len = isl;
        v.out_stall_k = osk; v.out_stall_len = osl; v.sel_fix_en = sfe; v.sel_fix = sf;
        v.busy_start_j = bsj; v.reset_y = ry; v.exp_cycles = ec; v.rnd = rnd;
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        int cyc = 0, acc = 0, it_x = 0, it_y = 0, it_sel = 0, res = 0;
        int istall = 0, ostall = 0, dones = 0, done_cyc = -1, post = 0;
        bit pulsed = 0, finished = 0, aborted = 0;
        logic [D-1:0] q[$];
        while (cyc < 1000 && post < 4 && !aborted) begin
            @(posedge clk); #1;
            // drive
            if (cyc == 0) begin
                start = 1'b1;
            end else if (v.busy_start_j >= 0 && !pulsed && acc == v.busy_start_j) begin
                start = 1'b1; pulsed = 1;
            end else begin
                start = 1'b0;
            end
            if (acc >= N) in_valid = 1'b0;
            else if (v.rnd) in_valid = 1'($urandom_range(0, 1));
            else in_valid = !(acc == v.in_stall_j && istall < v.in_stall_len);
            x_digit = (acc < N) ? dig(v.xv, acc) : 3'd0;
            y_digit = (acc < N) ? dig(v.yv, acc) : 3'd0;
            if (v.rnd) out_ready = 1'($urandom_range(0, 1));
            else out_ready = !(res == v.out_stall_k && ostall < v.out_stall_len);
            sel_digit = v.sel_fix_en ? v.sel_fix : D'($urandom);
            // sample
            @(negedge clk);
            if (finished) post++;
            if (pp_en && !pp_sel) begin
                check("ppx_a", 64'(pp_a), 64'(prefix(v.yv, it_x)));
                check("ppx_b", 64'(pp_b), 64'((it_x < N) ? dig(v.xv, it_x) : 3'd0));
                it_x++;
            end else if (pp_en && pp_sel) begin
                check("ppy_a", 64'(pp_a), 64'(prefix(v.xv, it_y + 1)));
                check("ppy_b", 64'(pp_b), 64'((it_y < N) ? dig(v.yv, it_y) : 3'd0));
                if (it_y == v.reset_y) begin
                    rst_n = 1'b0; #1;
                    check("rst_async_outs", 64'({busy, in_ready, out_valid, done, pp_en, sel_en, pp_a, pp_b}), 64'd0);
                    @(posedge clk); #1;
                    check("rst_edge_outs", 64'({busy, in_ready, out_valid, done, pp_en, sel_en, pp_a, pp_b, z_digit}), 64'd0);
                    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
                    rst_n = 1'b1;
                    aborted = 1;
                end
                it_y++;
            end else begin
                check("pp_idle_zero", 64'({pp_a, pp_b}), 64'd0);
            end
            if (!aborted) begin
                if (sel_en) begin
                    if (it_sel >= DELTA) q.push_back(sel_digit);
                    it_sel++;
                end
                if (in_ready && in_valid) acc++;
                if (!v.rnd && in_ready && !in_valid && acc == v.in_stall_j) begin
                    istall++;
                    check("in_stall_no_strobe", 64'({pp_en, sel_en}), 64'd0);
                end
                if (out_valid) begin
                    if (q.size() == 0) begin
                        check("out_without_result", 64'd1, 64'd0);
                    end else begin
                        check("z_digit", 64'(z_digit), 64'(q[0]));
                        if (out_ready) begin
                            void'(q.pop_front());
                            res++;
                        end else if (!v.rnd && res == v.out_stall_k) begin
                            ostall++;
                            check("out_stall_no_strobe", 64'({pp_en, sel_en}), 64'd0);
                        end
                    end
                end
                if (post >= 1) check("busy_after_done", 64'(busy), 64'd0);
                if (done) begin
                    dones++;
                    if (dones == 1) begin
                        done_cyc = cyc;
                        finished = 1;
                    end
                end
            end
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        if (!aborted) begin
            check("finished_in_budget", 64'(finished), 64'd1);
            check("done_pulses", 64'(dones), 64'd1);
            check("result_count", 64'(res), 64'(N));
            check("ppx_count", 64'(it_x), 64'(N + DELTA));
            check("ppy_count", 64'(it_y), 64'(N + DELTA));
            check("sel_count", 64'(it_sel), 64'(N + DELTA));
            check("accept_count", 64'(acc), 64'(N));
            if (v.exp_cycles >= 0) check("cycles_to_done", 64'(done_cyc), 64'(v.exp_cycles));
            if (!v.rnd && v.in_stall_len > 0) check("in_stall_len", 64'(istall), 64'(v.in_stall_len));
            if (!v.rnd && v.out_stall_len > 0) check("out_stall_len", 64'(ostall), 64'(v.out_stall_len));
        end
    endtask

    vec_t tbl[7];
    logic [D*N-1:0] ones;
    logic [D*N-1:0] rx, ry;

    initial begin
        ones = {N{3'b001}};
        tbl[0] = mk(ones, ones, -1, 0, -1, 0, 0, 3'd0, -1, -1, 50, 0);
        tbl[1] = mk(24'h000005, 24'h000002, -1, 0, -1, 0, 0, 3'd0, -1, -1, 50, 0);
        tbl[2] = mk(ones, ones, 4, 5, -1, 0, 0, 3'd0, -1, -1, 55, 0);
        tbl[3] = mk(ones, ones, -1, 0, 0, 4, 1, 3'b110, -1, -1, 54, 0);
        tbl[4] = mk(ones, ones, -1, 0, -1, 0, 0, 3'd0, 6, -1, 50, 0);
        tbl[5] = mk(ones, 24'h00_0fff, -1, 0, -1, 0, 0, 3'd0, -1, 2, -1, 0);
        tbl[6] = mk(24'h123456, 24'h654321, -1, 0, -1, 0, 0, 3'd0, -1, -1, 50, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'({busy, in_ready, pp_en, pp_sel, sel_en, out_valid, done, pp_a, pp_b, z_digit}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int t = 0; t < 7; t++) begin
            run_op(tbl[t]);
            repeat (2) @(posedge clk);
        end

        for (int r = 0; r < 8; r++) begin
            rx = (D*N)'($urandom);
            ry = (D*N)'($urandom);
            run_op(mk(rx, ry, -1, 0, -1, 0, 0, 3'd0, -1, -1, -1, 1));
            repeat (1) @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
